// File: rtl/alu_op_sequencer.sv
// Front-panel sequencer: debounces two pushbuttons and walks an external ALU through
// load A / load B / load opcode / execute / show, capturing the ALU outputs for display.
module alu_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_btn,
    input  logic        clr_btn,
    input  logic [9:0]  data_in,
    input  logic        cin_sw,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_flags,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [7:0]  Op,
    output logic        cin,
    output logic [15:0] result,
    output logic [4:0]  flags,
    output logic        result_valid,
    output logic [2:0]  state
);

    localparam int NUM_BTN = 2;
    localparam int BTN_STEP = 0;
    localparam int BTN_CLR  = 1;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ST_LOAD_A  = 3'd0;
    localparam logic [2:0] ST_LOAD_B  = 3'd1;
    localparam logic [2:0] ST_LOAD_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SHOW    = 3'd4;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press_event;

    assign btn_raw[BTN_STEP] = step_btn;
    assign btn_raw[BTN_CLR]  = clr_btn;

    // Per-button synchronizer, debouncer and press detector. Buttons idle high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             sync_meta_reg;
            logic             sync_reg;
            logic             level_reg;
            logic             press_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             differs;

            assign differs = (sync_reg != level_reg);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_meta_reg <= 1'b1;
                    sync_reg      <= 1'b1;
                    level_reg     <= 1'b1;
                    press_reg     <= 1'b0;
                    cnt_reg       <= '0;
                end else begin
                    sync_meta_reg <= btn_raw[gi];
                    sync_reg      <= sync_meta_reg;
                    press_reg     <= 1'b0;
                    if (!differs) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Level accepted after DEBOUNCE_CYCLES consecutive differing samples;
                        // a press is the high-to-low acceptance only.
                        level_reg <= sync_reg;
                        cnt_reg   <= '0;
                        press_reg <= level_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press_event[gi] = press_reg;
        end
    endgenerate

    logic step_event;
    logic clr_event;

    assign step_event = press_event[BTN_STEP];
    assign clr_event  = press_event[BTN_CLR];

    logic [2:0] state_reg;
    logic [2:0] state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_LOAD_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // Clear beats everything, including a step arriving on the same cycle.
    always_comb begin
        state_next = state_reg;
        if (clr_event) begin
            state_next = ST_LOAD_A;
        end else begin
            case (state_reg)
                ST_LOAD_A:  if (step_event) state_next = ST_LOAD_B;
                ST_LOAD_B:  if (step_event) state_next = ST_LOAD_OP;
                ST_LOAD_OP: if (step_event) state_next = ST_EXEC;
                ST_EXEC:    state_next = ST_SHOW;
                ST_SHOW:    if (step_event) state_next = ST_LOAD_A;
                default:    state_next = ST_LOAD_A;
            endcase
        end
    end

    logic load_a;
    logic load_b;
    logic load_op;
    logic capture;
    logic clear_valid;

    always_comb begin
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        capture     = 1'b0;
        clear_valid = clr_event;
        if (!clr_event) begin
            case (state_reg)
                ST_LOAD_A:  load_a      = step_event;
                ST_LOAD_B:  load_b      = step_event;
                ST_LOAD_OP: load_op     = step_event;
                ST_EXEC:    capture     = 1'b1;
                ST_SHOW:    clear_valid = step_event;
                default:    clear_valid = 1'b0;
            endcase
        end
    end

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [7:0]  op_reg;
    logic        cin_reg;
    logic [15:0] result_reg;
    logic [4:0]  flags_reg;
    logic        valid_reg;

    // Operand registers only move on their load edges, keeping ALU inputs steady through SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            cin_reg    <= 1'b0;
            result_reg <= '0;
            flags_reg  <= '0;
            valid_reg  <= 1'b0;
        end else begin
            if (load_a) a_reg <= {6'b0, data_in};
            if (load_b) b_reg <= {6'b0, data_in};
            if (load_op) begin
                op_reg  <= data_in[7:0];
                cin_reg <= cin_sw;
            end
            if (capture) begin
                result_reg <= alu_result;
                flags_reg  <= alu_flags;
                valid_reg  <= 1'b1;
            end else if (clear_valid) begin
                valid_reg  <= 1'b0;
            end
        end
    end

    assign A            = a_reg;
    assign B            = b_reg;
    assign Op           = op_reg;
    assign cin          = cin_reg;
    assign result       = result_reg;
    assign flags        = flags_reg;
    assign result_valid = valid_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with DEBOUNCE_CYCLES=4 and a small add/subtract ALU model.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        step_btn;
    logic        clr_btn;
    logic [9:0]  data_in;
    logic        cin_sw;
    logic [15:0] alu_result;
    logic [4:0]  alu_flags;
    logic [15:0] A;
    logic [15:0] B;
    logic [7:0]  Op;
    logic        cin;
    logic [15:0] result;
    logic [4:0]  flags;
    logic        result_valid;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .clr_btn(clr_btn),
        .data_in(data_in), .cin_sw(cin_sw), .alu_result(alu_result), .alu_flags(alu_flags),
        .A(A), .B(B), .Op(Op), .cin(cin), .result(result), .flags(flags),
        .result_valid(result_valid), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: Op 0x01 adds with carry, anything else subtracts; flags {z, c, n, v, p}.
    logic [16:0] alu_sum;
    always_comb begin
        if (Op == 8'h01) alu_sum = {1'b0, A} + {1'b0, B} + {16'b0, cin};
        else             alu_sum = {1'b0, A} - {1'b0, B};
        alu_result = alu_sum[15:0];
        alu_flags  = {alu_sum[15:0] == 16'h0, alu_sum[16], alu_sum[15], 1'b0, ^alu_sum[15:0]};
    end

    // Clean press: event lands 6 edges after the fall, FSM moves on the 7th.
    task automatic press_step(input logic [9:0] d, input logic c);
        data_in = d; cin_sw = c; step_btn = 1'b0;
        repeat (7) @(negedge clk);
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (A !== 16'h0) begin errors++; $display("FAIL reset_A got %h want 0000", A); end
        checks++; if (B !== 16'h0) begin errors++; $display("FAIL reset_B got %h want 0000", B); end
        checks++; if (Op !== 8'h0) begin errors++; $display("FAIL reset_Op got %h want 00", Op); end
        checks++; if (cin !== 1'b0) begin errors++; $display("FAIL reset_cin got %b want 0", cin); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
        checks++; if (flags !== 5'h0) begin errors++; $display("FAIL reset_flags got %b want 00000", flags); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_full_sequence();
        press_step(10'h005, 1'b0);
        checks++; if (state !== 3'd1 || A !== 16'h0005) begin errors++; $display("FAIL load_a got state=%0d A=%h want 1/0005", state, A); end
        press_step(10'h003, 1'b0);
        checks++; if (state !== 3'd2 || B !== 16'h0003) begin errors++; $display("FAIL load_b got state=%0d B=%h want 2/0003", state, B); end
        data_in = 10'h001; cin_sw = 1'b1; step_btn = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (state !== 3'd3 || Op !== 8'h01 || cin !== 1'b1 || result_valid !== 1'b0) begin
            errors++; $display("FAIL enter_exec got state=%0d Op=%h cin=%b valid=%b want 3/01/1/0", state, Op, cin, result_valid);
        end
        @(negedge clk);
        checks++; if (state !== 3'd4 || result !== 16'h0009 || flags !== 5'b00000 || result_valid !== 1'b1) begin
            errors++; $display("FAIL show got state=%0d result=%h flags=%b valid=%b want 4/0009/00000/1", state, result, flags, result_valid);
        end
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (state !== 3'd4 || A !== 16'h0005 || B !== 16'h0003) begin
            errors++; $display("FAIL show_hold got state=%0d A=%h B=%h want 4/0005/0003", state, A, B);
        end
        $display("full_sequence: A=%h B=%h Op=%h result=%h", A, B, Op, result);
    endtask

    task automatic test_show_exit();
        press_step(10'h2AA, 1'b0);
        checks++; if (state !== 3'd0 || result_valid !== 1'b0 || result !== 16'h0009 || A !== 16'h0005 || Op !== 8'h01) begin
            errors++; $display("FAIL show_exit got state=%0d valid=%b result=%h A=%h Op=%h want 0/0/0009/0005/01", state, result_valid, result, A, Op);
        end
        $display("show_exit: state=%0d", state);
    endtask

    task automatic test_hold();
        data_in = 10'h0AA; step_btn = 1'b0;
        repeat (20) @(negedge clk);
        data_in = 10'h155;
        repeat (80) @(negedge clk);
        checks++; if (state !== 3'd1 || A !== 16'h00AA) begin errors++; $display("FAIL hold got state=%0d A=%h want 1/00AA", state, A); end
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL hold_release got state=%0d want 1", state); end
        $display("hold: A=%h", A);
    endtask

    task automatic test_clear();
        clr_btn = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (state !== 3'd0 || A !== 16'h00AA || result !== 16'h0009 || result_valid !== 1'b0) begin
            errors++; $display("FAIL clear got state=%0d A=%h result=%h valid=%b want 0/00AA/0009/0", state, A, result, result_valid);
        end
        clr_btn = 1'b1;
        repeat (8) @(negedge clk);
        $display("clear: state=%0d", state);
    endtask

    task automatic test_bounce();
        data_in = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            step_btn = 1'b0; repeat (2) @(negedge clk);
            step_btn = 1'b1; repeat (2) @(negedge clk);
        end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL bounce_glitch got state=%0d want 0", state); end
        step_btn = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL bounce_early got state=%0d want 0", state); end
        @(negedge clk);
        checks++; if (state !== 3'd1 || A !== 16'h03FF) begin errors++; $display("FAIL bounce_event got state=%0d A=%h want 1/03FF", state, A); end
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        $display("bounce: state=%0d A=%h", state, A);
    endtask

    task automatic test_clear_priority();
        press_step(10'h3FF, 1'b0);
        checks++; if (state !== 3'd2 || B !== 16'h03FF) begin errors++; $display("FAIL prio_setup got state=%0d B=%h want 2/03FF", state, B); end
        data_in = 10'h3FF; step_btn = 1'b0; clr_btn = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (state !== 3'd0 || Op !== 8'h01 || result_valid !== 1'b0) begin
            errors++; $display("FAIL clear_priority got state=%0d Op=%h valid=%b want 0/01/0", state, Op, result_valid);
        end
        step_btn = 1'b1; clr_btn = 1'b1;
        repeat (8) @(negedge clk);
        $display("clear_priority: state=%0d", state);
    endtask

    task automatic test_max_operand();
        press_step(10'h3FF, 1'b0);
        press_step(10'h3FF, 1'b0);
        press_step(10'h3FF, 1'b0);
        checks++; if (state !== 3'd4 || Op !== 8'hFF || cin !== 1'b0 || A !== 16'h03FF) begin
            errors++; $display("FAIL max_operand got state=%0d Op=%h cin=%b A=%h want 4/FF/0/03FF", state, Op, cin, A);
        end
        checks++; if (result !== 16'h0000 || flags !== 5'b10000 || result_valid !== 1'b1) begin
            errors++; $display("FAIL max_capture got result=%h flags=%b valid=%b want 0000/10000/1", result, flags, result_valid);
        end
        press_step(10'h000, 1'b0);
        $display("max_operand: Op=%h flags=%b", Op, flags);
    endtask

    task automatic test_async_reset();
        press_step(10'h005, 1'b0);
        press_step(10'h003, 1'b0);
        press_step(10'h001, 1'b1);
        checks++; if (state !== 3'd4 || result !== 16'h0009) begin errors++; $display("FAIL areset_setup got state=%0d result=%h want 4/0009", state, result); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || A !== 16'h0 || B !== 16'h0 || Op !== 8'h0 || cin !== 1'b0 || result !== 16'h0 || flags !== 5'h0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset got state=%0d A=%h B=%h Op=%h cin=%b result=%h flags=%b valid=%b want all 0",
                state, A, B, Op, cin, result, flags, result_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("async_reset: state=%0d", state);
    endtask

    task automatic test_reset_in_exec();
        press_step(10'h011, 1'b0);
        press_step(10'h022, 1'b0);
        data_in = 10'h001; cin_sw = 1'b0; step_btn = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL exec_reach got state=%0d want 3", state); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state !== 3'd0 || result !== 16'h0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL exec_abort got state=%0d result=%h valid=%b want 0/0000/0", state, result, result_valid);
        end
        data_in = 10'h123;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL held_early got state=%0d want 0", state); end
        @(negedge clk);
        checks++; if (state !== 3'd1 || A !== 16'h0123) begin errors++; $display("FAIL held_event got state=%0d A=%h want 1/0123", state, A); end
        step_btn = 1'b1;
        repeat (8) @(negedge clk);
        $display("reset_in_exec: A=%h", A);
    endtask

    initial begin
        rst_n = 1'b0; step_btn = 1'b1; clr_btn = 1'b1; data_in = '0; cin_sw = 1'b0;
        test_reset();
        test_full_sequence();
        test_show_exit();
        test_hold();
        test_clear();
        test_bounce();
        test_clear_priority();
        test_max_operand();
        test_async_reset();
        test_reset_in_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
